alarm_escalation_fsm: RTL and testbench
=======================================

Name: alarm_escalation_fsm

Overview:
- Multi-channel successor of the post-operative alarm state machine.
- Monitors N_CH vital-sign alarm lines. A channel's alarm is confirmed only after it has been high for PERSIST consecutive cycles, which filters glitches.
- Escalates from ALARM to ALARM2 on a history match or when an unacknowledged alarm times out. Latches which channels caused the alarm and counts alarm events for the display/log logic.

Parameters:
- N_CH, 4, number of monitored alarm channels (1..16).
- PERSIST, 3, consecutive cycles an alarm line must be high before it is confirmed (1..255).
- ESC_TIMEOUT, 1000, cycles spent in ALARM before automatic escalation to ALARM2. 0 disables the timeout.
- TMR_W, 16, width of the escalation timer. Must satisfy ESC_TIMEOUT < 2^TMR_W.
- CNT_W, 8, width of the alarm event counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- sw  in  1  post-op monitoring enable switch.
- clear0  in  1  operator clear/acknowledge, level sampled.
- change  in  1  therapy change performed, level sampled.
- alarm  in  N_CH  per-channel raw alarm lines.
- history  in  N_CH  per-channel "prior alarm on record" flags.
- state_o  out  2  current state: IDLE=00, POST_OP=01, ALARM=10, ALARM2=11.
- enchange_al  out  1  high while in ALARM2.
- alarm_active  out  1  high while in ALARM or ALARM2.
- alarm_ch  out  N_CH  mask of confirmed channels latched on entry to ALARM.
- esc_timeout  out  1  ALARM2 was entered via timeout, not history.
- alarm_cnt  out  CNT_W  number of POST_OP->ALARM transitions, saturating.

Behaviour:
- Reset (rst=1 at a clk edge), all outputs 0 on the next cycle: state=IDLE, persistence counters=0, timer=0, alarm_ch=0, esc_timeout=0, alarm_cnt=0. rst overrides every other input, including mid-alarm.
- Persistence counters pc[i]:
  - If sw=1 and alarm[i]=1, pc[i] increments, saturating at PERSIST. Otherwise pc[i] resets to 0.
  - conf[i] = (pc[i]==PERSIST).
  - With alarm[i] first sampled high at edge 1, conf[i] is high after edge PERSIST, and state=ALARM after edge PERSIST+1.
- Counters run in every state.
- Transitions are evaluated per edge; the first matching rule wins.
- IDLE: sw=1 -> POST_OP; otherwise stay.
- POST_OP:
  - sw=0 -> IDLE.
  - |conf -> ALARM. On this transition: alarm_ch<=conf, alarm_cnt increments unless it is already all-ones, timer<=0.
  - Otherwise stay.
- ALARM:
  - sw=0 -> IDLE.
  - clear0=1 -> POST_OP (acknowledge).
  - |(conf & history & alarm_ch) -> ALARM2, esc_timeout<=0.
  - ESC_TIMEOUT!=0 and timer==ESC_TIMEOUT-1 -> ALARM2, esc_timeout<=1.
  - Otherwise stay, timer increments.
  - A history match and a timeout on the same edge resolve to history, so esc_timeout=0.
- ALARM2:
  - sw=0 -> IDLE.
  - change=1 or clear0=1 -> POST_OP.
  - Otherwise stay. alarm_ch and esc_timeout hold.
- alarm_ch and esc_timeout clear to 0 on any entry into IDLE or POST_OP.
- alarm_cnt clears only on rst.
- New confirmed channels arriving while in ALARM or ALARM2 do not modify alarm_ch.
- Outputs are a Moore decode of registered state plus registered fields. No combinational path from inputs to outputs.
- The state register is 2 bits, so the default branch is unreachable. If the state is ever illegal, the next state is IDLE.

Test Plan (N_CH=4, PERSIST=3, ESC_TIMEOUT=8, CNT_W=4):
1. Basic confirmation: reset, sw=1, then alarm=0010 held -> state_o=01 after 1 edge. pc[1] reaches 3 after 3 edges, and state_o=10 on the following edge. alarm_ch=0010, alarm_cnt=1, alarm_active=1.
2. Glitch filtering: alarm[0] pulsed high for 2 cycles, low for 1, repeated 5 times -> state stays 01 and alarm_cnt stays 0.
3. History escalation: in ALARM with alarm_ch=0010, assert history=0010 while alarm[1] stays high -> ALARM2 on the next edge. enchange_al=1, esc_timeout=0. Then change=1 for 1 cycle -> POST_OP, and alarm_ch=0000.
4. Timeout escalation: enter ALARM with history=0000 and no clear -> exactly 8 cycles in ALARM, then state_o=11 and esc_timeout=1. With clear0=1 in the ALARM cycle where timer=3 instead -> POST_OP, no escalation.
5. Priority/reset mid-op: in ALARM2, drive sw=0 and clear0=1 together -> IDLE, not POST_OP. In ALARM, assert rst for 1 cycle -> all outputs 0 next cycle, while alarm_cnt retained its value through the sw=0 case.
6. Saturation: generate 17 POST_OP->ALARM->POST_OP cycles via clear0 -> alarm_cnt=15 after the 15th and stays 15. ESC_TIMEOUT=0 build held in ALARM for 2000 cycles -> never escalates.

Source files
------------

// File: rtl/alarm_escalation_fsm_if.sv
// Alarm escalation FSM bus: monitoring inputs and
// status outputs grouped for the controller.
interface alarm_escalation_fsm_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);
  logic            sw;
  logic            clear0;
  logic            change;
  logic [N_CH-1:0] alarm;
  logic [N_CH-1:0] history;

  logic [1:0]       state_o;
  logic             enchange_al;
  logic             alarm_active;
  logic [N_CH-1:0]  alarm_ch;
  logic             esc_timeout;
  logic [CNT_W-1:0] alarm_cnt;

  modport master (
    output sw, clear0, change, alarm, history,
    input  state_o, enchange_al, alarm_active,
    input  alarm_ch, esc_timeout, alarm_cnt
  );

  modport slave (
    input  sw, clear0, change, alarm, history,
    output state_o, enchange_al, alarm_active,
    output alarm_ch, esc_timeout, alarm_cnt
  );
endinterface

// File: rtl/alarm_escalation_fsm.sv
// Multi-channel post-op alarm escalation FSM with
// glitch filtering, timeout escalation and event count.
module alarm_escalation_fsm #(
  parameter int N_CH        = 4,
  parameter int PERSIST     = 3,
  parameter int ESC_TIMEOUT = 1000,
  parameter int TMR_W       = 16,
  parameter int CNT_W       = 8
) (
  input logic                 clk,
  input logic                 rst,
  alarm_escalation_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    POST_OP = 2'b01,
    ALARM   = 2'b10,
    ALARM2  = 2'b11
  } state_t;

  localparam logic [7:0] PC_MAX = 8'(PERSIST);
  localparam bit TMO_EN = (ESC_TIMEOUT != 0);
  localparam logic [TMR_W-1:0] TMO_LAST =
    TMR_W'(TMO_EN ? ESC_TIMEOUT - 1 : 0);

  state_t           state;
  logic [7:0]       pc [N_CH];
  logic [N_CH-1:0]  conf;
  logic [TMR_W-1:0] timer;
  logic [N_CH-1:0]  ch_q;
  logic             esc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hist_hit;
  logic             tmo_hit;

  // A channel is confirmed once its run length saturates
  always_comb begin
    conf = '0;
    for (int i = 0; i < N_CH; i++) begin
      conf[i] = (pc[i] == PC_MAX);
    end
  end

  assign hist_hit = |(conf & bus.history & ch_q);
  assign tmo_hit  = TMO_EN && (timer == TMO_LAST);

  // Per-channel run-length counters, active in every state
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (rst || !bus.sw || !bus.alarm[i]) begin
        pc[i] <= '0;
      end else if (pc[i] != PC_MAX) begin
        pc[i] <= pc[i] + 8'd1;
      end
    end
  end

  // State machine with latched cause, escalation timer and count
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      ch_q  <= '0;
      esc_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.sw) state <= POST_OP;
        end
        POST_OP: begin
          if (!bus.sw) begin
            state <= IDLE;
          end else if (|conf) begin
            state <= ALARM;
            ch_q  <= conf;
            timer <= '0;
            if (~&cnt_q) cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ALARM: begin
          if (!bus.sw) begin
            state <= IDLE;
            ch_q  <= '0;
            esc_q <= 1'b0;
          end else if (bus.clear0) begin
            state <= POST_OP;
            ch_q  <= '0;
            esc_q <= 1'b0;
          end else if (hist_hit) begin
            state <= ALARM2;
            esc_q <= 1'b0;
          end else if (tmo_hit) begin
            state <= ALARM2;
            esc_q <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        ALARM2: begin
          if (!bus.sw) begin
            state <= IDLE;
            ch_q  <= '0;
            esc_q <= 1'b0;
          end else if (bus.change || bus.clear0) begin
            state <= POST_OP;
            ch_q  <= '0;
            esc_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ch_q  <= '0;
          esc_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state_o      = state;
  assign bus.enchange_al  = (state == ALARM2);
  assign bus.alarm_active = state[1];
  assign bus.alarm_ch     = ch_q;
  assign bus.esc_timeout  = esc_q;
  assign bus.alarm_cnt    = cnt_q;

endmodule

// File: tb/tb_alarm_escalation_fsm.sv
// Scoreboard bench for alarm_escalation_fsm:
// directed steps push expectations, a monitor checks them.
module tb_alarm_escalation_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;

  always #5 clk = ~clk;

  alarm_escalation_fsm_if #(.N_CH(4), .CNT_W(4)) b1 ();
  alarm_escalation_fsm_if #(.N_CH(4), .CNT_W(4)) b2 ();

  alarm_escalation_fsm #(
    .N_CH(4), .PERSIST(3), .ESC_TIMEOUT(8),
    .TMR_W(16), .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(b1)
  );

  alarm_escalation_fsm #(
    .N_CH(4), .PERSIST(3), .ESC_TIMEOUT(0),
    .TMR_W(16), .CNT_W(4)
  ) dut_nt (
    .clk(clk),
    .rst(rst2),
    .bus(b2)
  );

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] ch;
    logic       esc;
    logic [3:0] cnt;
  } exp_t;

  exp_t  exp_q [$];
  string name_q [$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Monitor: every cycle with a pending expectation is checked
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t        e;
      string       nm;
      logic [12:0] want;
      logic [12:0] got;
      e    = exp_q.pop_front();
      nm   = name_q.pop_front();
      want = {e.st, (e.st == 2'b11), e.st[1], e.ch, e.esc, e.cnt};
      got  = {b1.state_o, b1.enchange_al, b1.alarm_active,
              b1.alarm_ch, b1.esc_timeout, b1.alarm_cnt};
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got st=%b enc=%b act=%b ch=%b esc=%b cnt=%0d, want st=%b enc=%b act=%b ch=%b esc=%b cnt=%0d",
                 nm, got[12:11], got[10], got[9], got[8:5], got[4], got[3:0],
                 want[12:11], want[10], want[9], want[8:5], want[4], want[3:0]);
      end
    end
  end

  task automatic step(
    input logic       r,
    input logic       s,
    input logic       c0,
    input logic       chg,
    input logic [3:0] a,
    input logic [3:0] h,
    input logic       chk,
    input logic [1:0] es,
    input logic [3:0] ech,
    input logic       ee,
    input logic [3:0] ecnt,
    input string      nm
  );
    @(negedge clk);
    rst        = r;
    b1.sw      = s;
    b1.clear0  = c0;
    b1.change  = chg;
    b1.alarm   = a;
    b1.history = h;
    @(posedge clk);
    if (chk) begin
      exp_q.push_back('{es, ech, ee, ecnt});
      name_q.push_back(nm);
    end
  endtask

  initial begin
    int bad;
    int sat;
    b1.sw = 0; b1.clear0 = 0; b1.change = 0;
    b1.alarm = '0; b1.history = '0;
    b2.sw = 0; b2.clear0 = 0; b2.change = 0;
    b2.alarm = '0; b2.history = '0;

    // 1. reset and basic confirmation
    step(1,0,0,0,4'b0000,4'b0000, 1, 2'b00,4'b0000,0,4'd0, "reset");
    step(0,1,0,0,4'b0010,4'b0000, 1, 2'b01,4'b0000,0,4'd0, "to_postop");
    step(0,1,0,0,4'b0010,4'b0000, 1, 2'b01,4'b0000,0,4'd0, "pc2");
    step(0,1,0,0,4'b0010,4'b0000, 1, 2'b01,4'b0000,0,4'd0, "pc3");
    step(0,1,0,0,4'b0010,4'b0000, 1, 2'b10,4'b0010,0,4'd1, "confirm");

    // 3. history escalation then therapy change
    step(0,1,0,0,4'b0010,4'b0010, 1, 2'b11,4'b0010,0,4'd1, "hist_esc");
    step(0,1,0,1,4'b0010,4'b0010, 1, 2'b01,4'b0000,0,4'd1, "change");

    // 4. re-alarm, then timeout after 8 cycles in ALARM
    step(0,1,0,0,4'b0010,4'b0000, 1, 2'b10,4'b0010,0,4'd2, "realarm");
    for (int i = 0; i < 7; i++)
      step(0,1,0,0,4'b0010,4'b0000, 1, 2'b10,4'b0010,0,4'd2, "tmo_wait");
    step(0,1,0,0,4'b0010,4'b0000, 1, 2'b11,4'b0010,1,4'd2, "tmo_esc");
    step(0,1,1,0,4'b0000,4'b0000, 1, 2'b01,4'b0000,0,4'd2, "clr_alarm2");

    // 4b. acknowledge at timer=3 avoids escalation
    for (int i = 0; i < 3; i++)
      step(0,1,0,0,4'b0010,4'b0000, 1, 2'b01,4'b0000,0,4'd2, "pc_up");
    step(0,1,0,0,4'b0010,4'b0000, 1, 2'b10,4'b0010,0,4'd3, "alarm3");
    for (int i = 0; i < 3; i++)
      step(0,1,0,0,4'b0010,4'b0000, 1, 2'b10,4'b0010,0,4'd3, "tmr_run");
    step(0,1,1,0,4'b0000,4'b0000, 1, 2'b01,4'b0000,0,4'd3, "ack_t3");

    // 2. glitch filtering
    for (int r = 0; r < 5; r++) begin
      step(0,1,0,0,4'b0001,4'b0000, 1, 2'b01,4'b0000,0,4'd3, "glitch_hi");
      step(0,1,0,0,4'b0001,4'b0000, 1, 2'b01,4'b0000,0,4'd3, "glitch_hi");
      step(0,1,0,0,4'b0000,4'b0000, 1, 2'b01,4'b0000,0,4'd3, "glitch_lo");
    end

    // 5. sw=0 beats clear0 in ALARM2; rst mid-alarm
    for (int i = 0; i < 3; i++)
      step(0,1,0,0,4'b0001,4'b0000, 1, 2'b01,4'b0000,0,4'd3, "pc_ch0");
    step(0,1,0,0,4'b0001,4'b0000, 1, 2'b10,4'b0001,0,4'd4, "alarm4");
    step(0,1,0,0,4'b0001,4'b0001, 1, 2'b11,4'b0001,0,4'd4, "hist_ch0");
    step(0,0,1,0,4'b0001,4'b0001, 1, 2'b00,4'b0000,0,4'd4, "sw_off_prio");
    for (int i = 0; i < 3; i++)
      step(0,1,0,0,4'b0001,4'b0000, 1, 2'b01,4'b0000,0,4'd4, "restart");
    step(0,1,0,0,4'b0001,4'b0000, 1, 2'b10,4'b0001,0,4'd5, "alarm5");
    step(1,1,0,0,4'b0001,4'b0000, 1, 2'b00,4'b0000,0,4'd0, "rst_mid");
    step(0,0,0,0,4'b0000,4'b0000, 1, 2'b00,4'b0000,0,4'd0, "idle_after");

    // 6. counter saturation over 17 alarm events
    step(0,1,0,0,4'b0000,4'b0000, 1, 2'b01,4'b0000,0,4'd0, "sat_start");
    for (int k = 1; k <= 17; k++) begin
      sat = (k > 15) ? 15 : k;
      for (int i = 0; i < 3; i++)
        step(0,1,0,0,4'b0100,4'b0000, 0, 2'b01,4'b0000,0,4'd0, "");
      step(0,1,0,0,4'b0100,4'b0000, 1, 2'b10,4'b0100,0,4'(sat), "sat_alarm");
      step(0,1,1,0,4'b0000,4'b0000, 1, 2'b01,4'b0000,0,4'(sat), "sat_clear");
    end

    // 6b. timeout disabled: ALARM must hold for 2000 cycles
    @(negedge clk);
    rst2 = 1'b0;
    b2.sw = 1'b1;
    b2.alarm = 4'b0001;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (b2.state_o !== 2'b10) begin
      n_fail++;
      $display("FAIL nt_enter: got st=%b, want st=10", b2.state_o);
    end
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (b2.state_o !== 2'b10 || b2.esc_timeout !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL nt_hold: got %0d cycles out of ALARM, want 0", bad);
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++)
      @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
